// File: rtl/jtag_ir_dr_path.sv
// rtl/jtag_ir_dr_path.sv - JTAG IR, instruction decode, BYPASS/IDCODE/USER DRs and TDO retiming
// Shifts/captures on posedge tck from controller strobes; TDO is relaunched on negedge tck.
module jtag_ir_dr_path #(
  parameter int unsigned         IR_WIDTH      = 5,
  parameter logic [31:0]         IDCODE_VALUE  = 32'h1234_5679,
  parameter logic [IR_WIDTH-1:0] IDCODE_OPCODE = 'h01,
  parameter logic [IR_WIDTH-1:0] USER_OPCODE   = 'h02,
  parameter int unsigned         USER_WIDTH    = 32
) (
  input  logic                  tck,
  input  logic                  trst,
  input  logic                  tdi,
  input  logic                  tap_reset,
  input  logic                  shift_ir,
  input  logic                  capture_ir,
  input  logic                  update_ir,
  input  logic                  shift_dr,
  input  logic                  capture_dr,
  input  logic                  update_dr,
  input  logic                  tdo_en_in,
  input  logic [USER_WIDTH-1:0] user_capture_data,
  output logic [IR_WIDTH-1:0]   instr,
  output logic [USER_WIDTH-1:0] user_update_data,
  output logic                  user_update_strobe,
  output logic                  tdo,
  output logic                  tdo_oe
);

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    SEL_BYPASS,
    SEL_IDCODE,
    SEL_USER
  } dr_sel_e;

  logic [IR_WIDTH-1:0]   ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0]   instr_q, instr_d;
  logic                  bypass_sr_q, bypass_sr_d;
  logic [31:0]           idcode_sr_q, idcode_sr_d;
  logic [USER_WIDTH-1:0] user_sr_q, user_sr_d;
  logic [USER_WIDTH-1:0] user_update_data_q, user_update_data_d;
  logic                  user_update_strobe_q, user_update_strobe_d;
  logic                  tdo_q, tdo_d;
  logic                  tdo_oe_q, tdo_oe_d;
  logic [USER_WIDTH-1:0] user_shift;
  logic                  dr_bit;
  logic                  serial_out;
  dr_sel_e               dr_sel;

  // A 1-bit USER register has no upper slice to shift down
  generate
    if (USER_WIDTH == 1) begin : g_user_1
      assign user_shift = tdi;
    end else begin : g_user_n
      assign user_shift = {tdi, user_sr_q[USER_WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    dr_sel = SEL_BYPASS;
    if (instr_q == IDCODE_OPCODE) begin
      dr_sel = SEL_IDCODE;
    end else if (instr_q == USER_OPCODE) begin
      dr_sel = SEL_USER;
    end
  end

  always_comb begin
    ir_sr_d = ir_sr_q;
    if (capture_ir) begin
      ir_sr_d = IR_CAPTURE;
    end else if (shift_ir) begin
      ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};
    end

    instr_d = instr_q;
    if (!tap_reset) begin
      instr_d = IDCODE_OPCODE;
    end else if (update_ir && !capture_ir && !shift_ir) begin
      instr_d = ir_sr_q;
    end
  end

  always_comb begin
    bypass_sr_d          = bypass_sr_q;
    idcode_sr_d          = idcode_sr_q;
    user_sr_d            = user_sr_q;
    user_update_data_d   = user_update_data_q;
    user_update_strobe_d = 1'b0;
    case (dr_sel)
      SEL_BYPASS: begin
        if (capture_dr) begin
          bypass_sr_d = 1'b0;
        end else if (shift_dr) begin
          bypass_sr_d = tdi;
        end
      end
      SEL_IDCODE: begin
        if (capture_dr) begin
          idcode_sr_d = IDCODE_VALUE;
        end else if (shift_dr) begin
          idcode_sr_d = {tdi, idcode_sr_q[31:1]};
        end
      end
      SEL_USER: begin
        if (capture_dr) begin
          user_sr_d = user_capture_data;
        end else if (shift_dr) begin
          user_sr_d = user_shift;
        end else if (update_dr && tap_reset) begin
          user_update_data_d   = user_sr_q;
          user_update_strobe_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // IR wins the output mux so an illegal IR+DR overlap still streams the IR
  always_comb begin
    dr_bit = bypass_sr_q;
    case (dr_sel)
      SEL_IDCODE: dr_bit = idcode_sr_q[0];
      SEL_USER:   dr_bit = user_sr_q[0];
      default:    dr_bit = bypass_sr_q;
    endcase
    serial_out = shift_ir ? ir_sr_q[0] : dr_bit;
    tdo_oe_d   = tdo_en_in;
    tdo_d      = tdo_en_in ? serial_out : 1'b0;
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_sr_q              <= IR_CAPTURE;
      instr_q              <= IDCODE_OPCODE;
      bypass_sr_q          <= 1'b0;
      idcode_sr_q          <= IDCODE_VALUE;
      user_sr_q            <= '0;
      user_update_data_q   <= '0;
      user_update_strobe_q <= 1'b0;
    end else begin
      ir_sr_q              <= ir_sr_d;
      instr_q              <= instr_d;
      bypass_sr_q          <= bypass_sr_d;
      idcode_sr_q          <= idcode_sr_d;
      user_sr_q            <= user_sr_d;
      user_update_data_q   <= user_update_data_d;
      user_update_strobe_q <= user_update_strobe_d;
    end
  end

  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

  assign instr              = instr_q;
  assign user_update_data   = user_update_data_q;
  assign user_update_strobe = user_update_strobe_q;
  assign tdo                = tdo_q;
  assign tdo_oe             = tdo_oe_q;

endmodule

// File: tb/tb_jtag_ir_dr_path.sv
// tb/tb_jtag_ir_dr_path.sv - scoreboard bench for jtag_ir_dr_path
// Stimulus pushes expected TDO bits and update words; a negedge monitor pops and compares.
module tb_jtag_ir_dr_path;

  localparam logic [31:0] IDV = 32'h1234_5679;

  logic        tck = 1'b0;
  logic        trst, tdi, tap_reset;
  logic        shift_ir, capture_ir, update_ir;
  logic        shift_dr, capture_dr, update_dr, tdo_en_in;
  logic [31:0] user_capture_data;
  logic [4:0]  instr;
  logic [31:0] user_update_data;
  logic        user_update_strobe, tdo, tdo_oe;

  int vectors     = 0;
  int miscompares = 0;

  logic        exp_q[$];
  logic [31:0] upd_q[$];

  logic [4:0]  m_ir, m_instr;
  logic        m_byp;
  logic [31:0] m_id, m_user, m_upd;

  jtag_ir_dr_path #(
    .IR_WIDTH      (5),
    .IDCODE_VALUE  (IDV),
    .IDCODE_OPCODE (5'h01),
    .USER_OPCODE   (5'h02),
    .USER_WIDTH    (32)
  ) dut (
    .tck                (tck),
    .trst               (trst),
    .tdi                (tdi),
    .tap_reset          (tap_reset),
    .shift_ir           (shift_ir),
    .capture_ir         (capture_ir),
    .update_ir          (update_ir),
    .shift_dr           (shift_dr),
    .capture_dr         (capture_dr),
    .update_dr          (update_dr),
    .tdo_en_in          (tdo_en_in),
    .user_capture_data  (user_capture_data),
    .instr              (instr),
    .user_update_data   (user_update_data),
    .user_update_strobe (user_update_strobe),
    .tdo                (tdo),
    .tdo_oe             (tdo_oe)
  );

  always #5 tck = ~tck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge tck) begin
    #1;
    if (tdo_oe === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL tdo_extra: tdo_oe high with no bit expected, tdo=%b at %0t", tdo, $time);
      end else begin
        chk("tdo", {31'b0, tdo}, {31'b0, exp_q.pop_front()});
      end
    end else begin
      chk("tdo_idle", {31'b0, tdo}, 32'd0);
    end
    if (user_update_strobe === 1'b1) begin
      if (upd_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL strobe_extra: unexpected user_update_strobe, data=%h at %0t", user_update_data, $time);
      end else begin
        chk("user_update_data", user_update_data, upd_q.pop_front());
      end
    end
  end

  function automatic int sel_of(input logic [4:0] ins);
    if (ins == 5'h01) return 1;
    if (ins == 5'h02) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_ir = 5'h01; m_instr = 5'h01; m_byp = 1'b0;
    m_id = IDV;   m_user = 32'd0;  m_upd = 32'd0;
  endtask

  // One tck cycle: inputs change just after posedge, so the negedge TDO launch sees them
  task automatic drive(input logic ci, input logic si, input logic ui,
                       input logic cd, input logic sd, input logic ud,
                       input logic t = 1'b0, input logic tr = 1'b1);
    capture_ir = ci; shift_ir = si; update_ir = ui;
    capture_dr = cd; shift_dr = sd; update_dr = ud;
    tdi = t; tap_reset = tr; tdo_en_in = si | sd;
    @(posedge tck);
    #1;
  endtask

  // Serial stream out of a W-bit register = its start value (LSB first) followed by the tdi bits
  task automatic scan(input bit is_ir, input bit cap, input int n, input logic [127:0] bits, input bit upd);
    int w;
    int sel;
    logic [127:0] start, s, msk;
    sel = sel_of(m_instr);
    if (is_ir) begin
      w = 5; start = cap ? 128'd1 : {123'b0, m_ir};
    end else if (sel == 1) begin
      w = 32; start = cap ? {96'b0, IDV} : {96'b0, m_id};
    end else if (sel == 2) begin
      w = 32; start = cap ? {96'b0, user_capture_data} : {96'b0, m_user};
    end else begin
      w = 1; start = cap ? 128'd0 : {127'b0, m_byp};
    end
    msk = (128'd1 << n) - 128'd1;
    s = start | ((bits & msk) << w);
    if (cap) drive(is_ir, 1'b0, 1'b0, !is_ir, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(s[i]);
      drive(1'b0, is_ir, 1'b0, 1'b0, !is_ir, 1'b0, bits[i]);
    end
    s = s >> n;
    if (is_ir) m_ir = s[4:0];
    else if (sel == 1) m_id = s[31:0];
    else if (sel == 2) m_user = s[31:0];
    else m_byp = s[0];
    if (upd) begin
      drive(1'b0, 1'b0, is_ir, 1'b0, 1'b0, !is_ir);
      if (is_ir) begin
        m_instr = m_ir;
      end else if (sel == 2) begin
        m_upd = m_user;
        upd_q.push_back(m_user);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] bits;
    logic [127:0] s_ir, s_u;
    logic [4:0]   op;
    trst = 1'b0; tdi = 1'b0; tap_reset = 1'b0; tdo_en_in = 1'b0;
    shift_ir = 1'b0; capture_ir = 1'b0; update_ir = 1'b0;
    shift_dr = 1'b0; capture_dr = 1'b0; update_dr = 1'b0;
    user_capture_data = 32'd0;
    model_reset();
    repeat (2) @(posedge tck);
    #1;
    chk("rst_tdo", {31'b0, tdo}, 32'd0);
    chk("rst_tdo_oe", {31'b0, tdo_oe}, 32'd0);
    chk("rst_instr", {27'b0, instr}, 32'h01);
    chk("rst_user_update_data", user_update_data, 32'd0);
    chk("rst_strobe", {31'b0, user_update_strobe}, 32'd0);
    trst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    scan(1'b0, 1'b1, 32, 128'd0, 1'b0);

    scan(1'b1, 1'b1, 5, 128'h1F, 1'b1);
    chk("instr_bypass", {27'b0, instr}, 32'h1F);
    scan(1'b0, 1'b1, 3, 128'b101, 1'b0);

    scan(1'b1, 1'b1, 5, 128'h02, 1'b1);
    chk("instr_user", {27'b0, instr}, 32'h02);
    user_capture_data = 32'hDEAD_BEEF;
    scan(1'b0, 1'b1, 32, 128'hCAFE_F00D, 1'b1);
    chk("user_update_cafe", user_update_data, 32'hCAFE_F00D);

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    m_instr = 5'h01;
    chk("tap_reset_instr", {27'b0, instr}, {27'b0, m_instr});
    chk("tap_reset_upd_data", user_update_data, m_upd);
    chk("tap_reset_strobe", {31'b0, user_update_strobe}, 32'd0);
    scan(1'b0, 1'b1, 32, {96'b0, $urandom}, 1'b1);

    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 3))
        0: op = 5'h01;
        1: op = 5'h02;
        2: op = 5'h1F;
        default: op = 5'($urandom);
      endcase
      bits = {123'b0, op} << $urandom_range(0, 3);
      bits = bits | ({96'b0, $urandom} << 8);
      scan(1'b1, ($urandom_range(0, 5) != 0), 5 + $urandom_range(0, 3), bits, ($urandom_range(0, 4) != 0));
      chk("instr_rand", {27'b0, instr}, {27'b0, m_instr});
      user_capture_data = $urandom;
      scan(1'b0, ($urandom_range(0, 3) != 0), $urandom_range(1, 40), {64'b0, $urandom, $urandom}, $urandom_range(0, 1) == 1);
      chk("upd_data_rand", user_update_data, m_upd);
    end

    // Illegal overlap of IR and DR strobes: both act, TDO follows the IR
    scan(1'b1, 1'b1, 5, 128'h02, 1'b1);
    user_capture_data = $urandom;
    bits = {96'b0, $urandom} & 128'h1F;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    s_ir = 128'd1 | (bits << 5);
    s_u  = {96'b0, user_capture_data} | (bits << 32);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(s_ir[i]);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, bits[i]);
    end
    s_ir = s_ir >> 5;
    s_u  = s_u >> 5;
    m_ir = s_ir[4:0];
    m_user = s_u[31:0];
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    scan(1'b0, 1'b0, 32, {96'b0, $urandom}, 1'b1);
    scan(1'b1, 1'b0, 5, 128'h02, 1'b1);
    chk("instr_after_overlap", {27'b0, instr}, 32'h02);

    // trst mid USER shift
    user_capture_data = $urandom;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    s_u = {96'b0, user_capture_data};
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(s_u[i]);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    exp_q.push_back(s_u[10]);
    shift_dr = 1'b1; tdo_en_in = 1'b1; tdi = 1'b1;
    @(negedge tck);
    #3;
    trst = 1'b0;
    #1;
    chk("trst_tdo", {31'b0, tdo}, 32'd0);
    chk("trst_tdo_oe", {31'b0, tdo_oe}, 32'd0);
    chk("trst_instr", {27'b0, instr}, 32'h01);
    chk("trst_upd_data", user_update_data, 32'd0);
    shift_dr = 1'b0; tdo_en_in = 1'b0; tdi = 1'b0;
    trst = 1'b1;
    model_reset();
    @(posedge tck);
    #1;
    scan(1'b1, 1'b1, 5, 128'h02, 1'b1);
    scan(1'b0, 1'b0, 32, {96'b0, $urandom}, 1'b1);

    // capture_ir with no shift then update selects IDCODE
    scan(1'b1, 1'b1, 0, 128'd0, 1'b1);
    chk("instr_capture_only", {27'b0, instr}, 32'h01);
    scan(1'b0, 1'b1, 32, {96'b0, $urandom}, 1'b0);

    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tdo_queue_drained", exp_q.size(), 32'd0);
    chk("upd_queue_drained", upd_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
